// File: rtl/miner_pkg.sv
// Shared types and default widths for the BtcMiner nonce scheduling logic.
package miner_pkg;

  localparam int NONCE_W_DEF = 32;
  localparam int TGT_W_DEF   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/miner_nonce_scheduler.sv
// Sweeps a nonce range through the double-SHA core, one hash outstanding at a time,
// and records nonces whose top hash slice is at or below the target.
//
// state | meaning
// IDLE  | no sweep; waiting for cfg_go
// ISSUE | offering the current nonce to the core
// WAIT  | one hash outstanding
// DRAIN | aborted; swallowing the outstanding result
module miner_nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int TGT_W   = TGT_W_DEF
) (
  input  logic               clk,
  input  logic               wb_rst,
  input  logic               cfg_go,
  input  logic               cfg_stop,
  input  logic               cfg_stop_on_found,
  input  logic [NONCE_W-1:0] cfg_start_nonce,
  input  logic [NONCE_W-1:0] cfg_end_nonce,
  input  logic [TGT_W-1:0]   cfg_target,
  input  logic               core_ready,
  output logic               core_start,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_done,
  input  logic [TGT_W-1:0]   core_hash_hi,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [NONCE_W-1:0] hashes_done,
  output logic               range_err
);

  state_e             r_state;
  state_e             w_next;
  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_end;
  logic [TGT_W-1:0]   r_target;
  logic               r_sof;
  logic               r_done;
  logic               r_found;
  logic               r_found_valid;
  logic [NONCE_W-1:0] r_found_nonce;
  logic [NONCE_W-1:0] r_hashes;
  logic               r_range_err;

  logic w_idle;
  logic w_go_ok;
  logic w_go_bad;
  logic w_result;
  logic w_win;
  logic w_last;
  logic w_finish;
  logic w_done_set;

  // A stop in the same cycle as go (or as a result) always takes priority.
  assign w_idle   = (r_state == IDLE);
  assign w_go_ok  = w_idle && cfg_go && !cfg_stop && (cfg_start_nonce <= cfg_end_nonce);
  assign w_go_bad = w_idle && cfg_go && !cfg_stop && (cfg_start_nonce > cfg_end_nonce);
  assign w_result = (r_state == WAIT) && core_done && !cfg_stop;
  assign w_win    = (core_hash_hi <= r_target);
  assign w_last   = (r_nonce == r_end);
  assign w_finish = w_result && ((w_win && r_sof) || w_last);

  always_ff @(posedge clk) begin
    if (wb_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go_ok) w_next = ISSUE;
      ISSUE: begin
        if (cfg_stop)        w_next = IDLE;
        else if (core_ready) w_next = WAIT;
      end
      WAIT: begin
        if (cfg_stop)       w_next = core_done ? IDLE : DRAIN;
        else if (core_done) w_next = w_finish ? IDLE : ISSUE;
      end
      DRAIN:   if (core_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    core_start = (r_state == ISSUE) && core_ready && !cfg_stop;
    busy       = !w_idle;
    w_done_set = w_go_bad || (!w_idle && (w_next == IDLE));
  end

  always_ff @(posedge clk) begin
    if (wb_rst) begin
      r_nonce       <= '0;
      r_end         <= '0;
      r_target      <= '0;
      r_sof         <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_hashes      <= '0;
      r_range_err   <= 1'b0;
    end else begin
      r_done  <= w_done_set;
      r_found <= 1'b0;
      if (w_go_ok) begin
        r_nonce       <= cfg_start_nonce;
        r_end         <= cfg_end_nonce;
        r_target      <= cfg_target;
        r_sof         <= cfg_stop_on_found;
        r_hashes      <= '0;
        r_found_valid <= 1'b0;
        r_range_err   <= 1'b0;
      end else if (w_go_bad) begin
        r_range_err <= 1'b1;
      end
      if (w_result) begin
        if (r_hashes != '1) r_hashes <= r_hashes + 1'b1;
        if (w_win) begin
          r_found       <= 1'b1;
          r_found_valid <= 1'b1;
          r_found_nonce <= r_nonce;
        end
        // Last-nonce compare precedes the increment, so an all-ones end never wraps.
        if (!w_finish) r_nonce <= r_nonce + 1'b1;
      end
    end
  end

  assign core_nonce  = r_nonce;
  assign done        = r_done;
  assign found       = r_found;
  assign found_valid = r_found_valid;
  assign found_nonce = r_found_nonce;
  assign hashes_done = r_hashes;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Bench for miner_nonce_scheduler: directed table, hand-written corner sequences,
// and randomized sweeps against a range-walking reference model.
module tb_miner_nonce_scheduler;

  logic        clk = 1'b0;
  logic        wb_rst;
  logic        cfg_go, cfg_stop, cfg_stop_on_found;
  logic [31:0] cfg_start_nonce, cfg_end_nonce;
  logic [63:0] cfg_target;
  logic        core_ready = 1'b0;
  logic        core_start;
  logic [31:0] core_nonce;
  logic        core_done;
  logic [63:0] core_hash_hi;
  logic        busy, done, found, found_valid;
  logic [31:0] found_nonce, hashes_done;
  logic        range_err;

  always #5 clk = ~clk;

  miner_nonce_scheduler #(.NONCE_W(32), .TGT_W(64)) dut (
    .clk(clk), .wb_rst(wb_rst), .cfg_go(cfg_go), .cfg_stop(cfg_stop),
    .cfg_stop_on_found(cfg_stop_on_found), .cfg_start_nonce(cfg_start_nonce),
    .cfg_end_nonce(cfg_end_nonce), .cfg_target(cfg_target), .core_ready(core_ready),
    .core_start(core_start), .core_nonce(core_nonce), .core_done(core_done),
    .core_hash_hi(core_hash_hi), .busy(busy), .done(done), .found(found),
    .found_valid(found_valid), .found_nonce(found_nonce), .hashes_done(hashes_done),
    .range_err(range_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          lat = 1;
  bit          hm_rand = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rdy_force = 1'b1;
  logic [31:0] win_nonce = 32'h0;
  logic [31:0] seed = 32'h0;
  int          go_cyc = 0;

  logic [31:0] starts_q[$];
  int          start_cyc_q[$];
  int          cd_cyc = -1;
  int          done_cyc = -1;
  int          done_cnt = 0;
  int          found_cnt = 0;

  bit          m_fv = 1'b0;
  bit          m_re = 1'b0;
  logic [31:0] m_fn = 32'h0;
  logic [31:0] m_hd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] hash_of(input logic [31:0] n);
    logic [31:0] m;
    if (hm_rand) begin
      m = (n * 32'h9E3779B1) ^ seed;
      return {60'd0, m[31:28]};
    end
    return (n == win_nonce) ? 64'd0 : 64'd5;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      core_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Core model: accepts a start, answers after lat cycles.
  initial begin
    int          pend;
    logic [31:0] pend_nonce;
    pend = 0;
    pend_nonce = 32'h0;
    core_done = 1'b0;
    core_hash_hi = 64'h0;
    forever begin
      @(posedge clk);
      #2;
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_hash_hi = hash_of(pend_nonce);
          cd_cyc = cyc;
        end
      end
      if (core_start) begin
        pend_nonce = core_nonce;
        pend = lat;
        starts_q.push_back(core_nonce);
        start_cyc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (found) found_cnt <= found_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t,
                    input bit sof, input bit with_stop);
    @(posedge clk);
    #1;
    cfg_start_nonce = s;
    cfg_end_nonce = e;
    cfg_target = t;
    cfg_stop_on_found = sof;
    cfg_go = 1'b1;
    cfg_stop = with_stop;
    go_cyc = cyc;
    @(posedge clk);
    #1;
    cfg_go = 1'b0;
    cfg_stop = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1;
    cfg_stop = 1'b1;
    @(posedge clk);
    #1;
    cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int db, input int budget);
    int k;
    k = 0;
    while (done_cnt == db && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({nm, " done timeout"}, 64'(k < budget), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(input int sb);
    int k;
    k = 0;
    while (starts_q.size() == sb && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("first start timeout", 64'(k < 100), 64'd1);
  endtask

  task automatic run_sweep(input string nm, input logic [31:0] s, input logic [31:0] e,
                           input logic [63:0] t, input bit sof, input logic [31:0] exp_q[$],
                           input logic [31:0] exp_hd, input bit exp_fv,
                           input logic [31:0] exp_fn, input int exp_fc, input bit exp_re);
    int sb, db, fb, seq_bad;
    sb = starts_q.size();
    db = done_cnt;
    fb = found_cnt;
    seq_bad = 0;
    go(s, e, t, sof, 1'b0);
    wait_done(nm, db, 30 * (exp_q.size() + 1) + 60);
    check({nm, " start count"}, 64'(starts_q.size() - sb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && sb + i < starts_q.size(); i++)
      if (starts_q[sb + i] !== exp_q[i]) seq_bad++;
    check({nm, " nonce order errors"}, 64'(seq_bad), 64'd0);
    check({nm, " hashes_done"}, 64'(hashes_done), 64'(exp_hd));
    check({nm, " found_valid"}, 64'(found_valid), 64'(exp_fv));
    check({nm, " found_nonce"}, 64'(found_nonce), 64'(exp_fn));
    check({nm, " found pulses"}, 64'(found_cnt - fb), 64'(exp_fc));
    check({nm, " done pulses"}, 64'(done_cnt - db), 64'd1);
    check({nm, " range_err"}, 64'(range_err), 64'(exp_re));
    check({nm, " busy after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [63:0] t;
    bit          sof;
    logic [31:0] win;
    int          n_starts;
    logic [31:0] hd;
    bit          fv;
    logic [31:0] fn;
    int          fc;
    bit          re;
  } vec_t;

  vec_t tv[5];

  initial begin
    int sb, db, fb;
    logic [31:0] q[$];

    tv[0] = '{32'h10, 32'h13, 64'd0, 1'b0, 32'h0, 4, 32'd4, 1'b0, 32'h0, 0, 1'b0};
    tv[1] = '{32'h10, 32'h13, 64'd0, 1'b1, 32'h12, 3, 32'd3, 1'b1, 32'h12, 1, 1'b0};
    tv[2] = '{32'h10, 32'h13, 64'd0, 1'b0, 32'h12, 4, 32'd4, 1'b1, 32'h12, 1, 1'b0};
    tv[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 64'd0, 1'b0, 32'h0, 2, 32'd2, 1'b0, 32'h12, 0, 1'b0};
    tv[4] = '{32'h5, 32'h3, 64'd0, 1'b0, 32'h0, 0, 32'd2, 1'b0, 32'h12, 0, 1'b1};

    wb_rst = 1'b1;
    cfg_go = 1'b0;
    cfg_stop = 1'b0;
    cfg_stop_on_found = 1'b0;
    cfg_start_nonce = 32'h0;
    cfg_end_nonce = 32'h0;
    cfg_target = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    wb_rst = 1'b0;
    @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst found", 64'(found), 64'd0);
    check("rst found_valid", 64'(found_valid), 64'd0);
    check("rst found_nonce", 64'(found_nonce), 64'd0);
    check("rst hashes_done", 64'(hashes_done), 64'd0);
    check("rst range_err", 64'(range_err), 64'd0);
    check("rst core_start", 64'(core_start), 64'd0);
    check("rst core_nonce", 64'(core_nonce), 64'd0);

    for (int i = 0; i < 5; i++) begin
      hm_rand = 1'b0;
      lat = 1;
      win_nonce = tv[i].win;
      q.delete();
      for (int j = 0; j < tv[i].n_starts; j++) q.push_back(tv[i].s + 32'(j));
      run_sweep($sformatf("vec%0d", i), tv[i].s, tv[i].e, tv[i].t, tv[i].sof, q,
                tv[i].hd, tv[i].fv, tv[i].fn, tv[i].fc, tv[i].re);
      m_fv = tv[i].fv;
      m_fn = tv[i].fn;
      m_hd = tv[i].hd;
      m_re = tv[i].re;
    end

    // Abort while a winning hash is outstanding: result must be swallowed.
    lat = 5;
    win_nonce = 32'h10;
    sb = starts_q.size();
    db = done_cnt;
    fb = found_cnt;
    go(32'h10, 32'h13, 64'd0, 1'b0, 1'b0);
    wait_start(sb);
    pulse_stop();
    @(negedge clk);
    check("drain busy", 64'(busy), 64'd1);
    wait_done("drain", db, 60);
    check("drain done after result", 64'(done_cyc - cd_cyc), 64'd1);
    check("drain found pulses", 64'(found_cnt - fb), 64'd0);
    check("drain found_valid", 64'(found_valid), 64'd0);
    check("drain found_nonce", 64'(found_nonce), 64'h12);
    check("drain hashes_done", 64'(hashes_done), 64'd0);
    check("drain starts", 64'(starts_q.size() - sb), 64'd1);
    m_fv = 1'b0;
    m_hd = 32'h0;
    m_re = 1'b0;

    // Reset while waiting: everything clears, late result ignored.
    win_nonce = 32'h30;
    sb = starts_q.size();
    db = done_cnt;
    fb = found_cnt;
    go(32'h30, 32'h31, 64'd0, 1'b0, 1'b0);
    wait_start(sb);
    @(posedge clk);
    #1;
    wb_rst = 1'b1;
    @(posedge clk);
    #1;
    wb_rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst found_nonce", 64'(found_nonce), 64'd0);
    check("midrst core_start", 64'(core_start), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    repeat (10) @(negedge clk);
    check("midrst late hashes_done", 64'(hashes_done), 64'd0);
    check("midrst late found pulses", 64'(found_cnt - fb), 64'd0);
    check("midrst late found_valid", 64'(found_valid), 64'd0);
    check("midrst no done", 64'(done_cnt - db), 64'd0);
    check("midrst no restart", 64'(starts_q.size() - sb), 64'd1);
    m_fv = 1'b0;
    m_fn = 32'h0;
    m_hd = 32'h0;
    m_re = 1'b0;

    // core_ready held low for 10 cycles in ISSUE.
    lat = 1;
    win_nonce = 32'h0;
    rdy_force = 1'b0;
    @(posedge clk);
    sb = starts_q.size();
    db = done_cnt;
    go(32'h20, 32'h21, 64'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("stall no start", 64'(starts_q.size() - sb), 64'd0);
    check("stall busy", 64'(busy), 64'd1);
    check("stall core_nonce", 64'(core_nonce), 64'h20);
    check("stall hashes_done", 64'(hashes_done), 64'd0);
    rdy_force = 1'b1;
    wait_done("stall", db, 60);
    check("stall starts", 64'(starts_q.size() - sb), 64'd2);
    if (starts_q.size() > sb) begin
      check("stall first nonce", 64'(starts_q[sb]), 64'h20);
      check("stall start delayed", 64'(start_cyc_q[sb] - go_cyc >= 11), 64'd1);
    end
    check("stall hashes_done end", 64'(hashes_done), 64'd2);
    m_hd = 32'd2;

    // Go and stop together in IDLE: nothing starts.
    sb = starts_q.size();
    db = done_cnt;
    go(32'h40, 32'h41, 64'd0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("gostop starts", 64'(starts_q.size() - sb), 64'd0);
    check("gostop busy", 64'(busy), 64'd0);
    check("gostop done", 64'(done_cnt - db), 64'd0);
    check("gostop hashes_done", 64'(hashes_done), 64'd2);

    // Stop while stuck in ISSUE.
    rdy_force = 1'b0;
    @(posedge clk);
    db = done_cnt;
    go(32'h50, 32'h52, 64'd0, 1'b0, 1'b0);
    pulse_stop();
    rdy_force = 1'b1;
    repeat (4) @(negedge clk);
    check("issue stop done", 64'(done_cnt - db), 64'd1);
    check("issue stop starts", 64'(starts_q.size() - sb), 64'd0);
    check("issue stop busy", 64'(busy), 64'd0);
    check("issue stop hashes_done", 64'(hashes_done), 64'd0);
    m_hd = 32'h0;

    // Randomized sweeps against the range-walking model.
    hm_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [31:0] s, e;
      logic [63:0] t;
      longint unsigned e64;
      bit sof;
      int fc, kind;
      seed = $urandom;
      lat = int'($urandom_range(1, 3));
      t = 64'($urandom_range(0, 3));
      sof = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        s = 32'($urandom_range(5, 1000));
        e = s - 32'($urandom_range(1, 5));
      end else begin
        s = (kind == 1) ? 32'hFFFFFFFF - 32'($urandom_range(0, 5)) : $urandom;
        e64 = 64'(s) + 64'($urandom_range(0, 9));
        e = (e64 > 64'hFFFFFFFF) ? 32'hFFFFFFFF : e64[31:0];
      end
      q.delete();
      fc = 0;
      if (s > e) begin
        m_re = 1'b1;
      end else begin
        m_re = 1'b0;
        m_fv = 1'b0;
        for (longint unsigned n = 64'(s); n <= 64'(e); n++) begin
          q.push_back(n[31:0]);
          if (hash_of(n[31:0]) <= t) begin
            fc++;
            m_fv = 1'b1;
            m_fn = n[31:0];
            if (sof) break;
          end
        end
        m_hd = 32'(q.size());
      end
      run_sweep($sformatf("rnd%0d", r), s, e, t, sof, q, m_hd, m_fv, m_fn, fc, m_re);
    end
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
